bus_master_8088: RTL and testbench
==================================

BUS_MASTER_8088 -- requirements
Module: bus_master_8088

Interface
REQ-001 Parameter ADDR_WIDTH, 20, width of Address and req_addr.
REQ-002 Parameter DATA_WIDTH, 8, width of the data paths.
REQ-003 Parameter WAIT_LIMIT, 15, maximum consecutive wait states before abort (WAIT_STATE_EN only).
REQ-004 CLK  in  1  single clock; all logic on posedge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 req  in  1  host request, level; qualified by req_ready.
REQ-007 req_write  in  1  1 = write cycle, 0 = read cycle.
REQ-008 req_io  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-009 req_addr  in  ADDR_WIDTH  cycle address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 req_ready  out  1  high when a request can be accepted.
REQ-012 done  out  1  one-cycle pulse at cycle completion.
REQ-013 err  out  1  valid with done; 1 = wait-state timeout abort.
REQ-014 rdata  out  DATA_WIDTH  captured read data; holds until the next read completes.
REQ-015 ALE  out  1  address latch enable, active-high.
REQ-016 IOM  out  1  1 = I/O, 0 = memory.
REQ-017 RD, WR  out  1 each  active-low strobes.
REQ-018 Address  out  ADDR_WIDTH  bus address.
REQ-019 data_out  out  DATA_WIDTH  write data driven to the bus.
REQ-020 data_oe  out  1  high while data_out is valid for a write.
REQ-021 data_in  in  DATA_WIDTH  read data from the responder.
REQ-022 READY  in  1  responder ready; used only with WAIT_STATE_EN.

Function
REQ-023 The FSM SHALL have states IDLE, T1, T2, T3, TW, T4; all bus outputs are registered.
REQ-024 req_ready SHALL equal 1 in IDLE and T4 and 0 in all other states.
REQ-025 req && req_ready SHALL capture all req_* fields and move to T1 on the next edge; the accepted cycle, plus one idle cycle, takes exactly 5 cycles (IDLE/T4, T1, T2, T3, T4) when there are no waits.
REQ-026 T1: ALE=1, Address=captured address, IOM=req_io, RD=WR=1.
REQ-027 T2, T3, TW: ALE=0; RD=0 for a read or WR=0 for a write; the other strobe stays 1.
REQ-028 Writes: data_oe=1 and data_out=req_wdata from T2 through T4 inclusive.
REQ-029 Address and IOM SHALL remain stable from T1 through T4 inclusive.
REQ-030 A read SHALL capture data_in into rdata on the edge leaving T3, or leaving TW, toward T4.
REQ-031 T4: RD=WR=1, done=1 for exactly one cycle; err=0 unless REQ-037 applies.
REQ-032 T4 with req=1 SHALL go straight to T1 (back-to-back, no IDLE gap); otherwise go to IDLE.
REQ-033 IDLE: ALE=0, RD=WR=1, data_oe=0; Address and IOM hold their last value.
REQ-034 req_* inputs SHALL be ignored outside acceptance; a change mid-cycle has no effect.

Reset
REQ-035 RESET=1 SHALL force immediately, without waiting for a clock: state IDLE, ALE=0, RD=WR=1, IOM=0, Address=0, data_out=0, data_oe=0, done=0, err=0, rdata=0, wait counter 0.
REQ-036 Reset mid-cycle SHALL abort the cycle with no done pulse; the first accepted request after release starts a fresh T1.

Configuration
REQ-037 With macro BUS_MASTER_WAIT_STATE_EN defined:
- T3 with READY=0 goes to TW; TW repeats while READY=0; READY=1 goes to T4.
- A 4-bit-minimum counter counts TW cycles.
- WAIT_LIMIT consecutive TW cycles SHALL force T4 with err=1 and rdata unchanged.
REQ-038 Without the macro: READY is ignored, TW is unreachable, err is constant 0, and T3 always goes to T4.

Verification
REQ-039 Memory read: req_addr=0x00010, req_io=0, data_in=0xA5 -> ALE high one cycle, RD low in T2-T3, done in cycle 5, rdata=0xA5.
REQ-040 I/O write: req_io=1, req_addr=0x003F8, req_wdata=0x3C -> IOM=1 T1-T4, WR low in T2-T3, data_oe high T2-T4 with 0x3C, done with err=0.
REQ-041 Back-to-back: req held high across two reads (0x00100, then 0x00101) -> second ALE in the cycle after the first done; no IDLE between.
REQ-042 With the macro, READY=0 for 3 cycles at T3 -> 3 TW cycles, RD held low, done 3 cycles later, err=0.
REQ-043 With the macro, READY held 0 -> after 15 TW cycles, done=1, err=1, rdata unchanged.
REQ-044 RESET asserted during T2 of a write -> WR=1 and data_oe=0 immediately, no done; a new read after release completes normally.

Source files
------------

// File: rtl/bus_master_8088.sv
// 8088-style bus cycle master: IDLE/T1/T2/T3/TW/T4 with registered bus outputs.
// Optional wait-state support with READY timeout under `BUS_MASTER_WAIT_STATE_EN.
module bus_master_8088 #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req,
    input  logic                  req_write,
    input  logic                  req_io,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ALE,
    output logic                  IOM,
    output logic                  RD,
    output logic                  WR,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  READY
);

    localparam int CW = ($clog2(WAIT_LIMIT + 1) > 4) ? $clog2(WAIT_LIMIT + 1) : 4;

    typedef enum logic [2:0] {
        IDLE, T1, T2, T3, TW, T4
    } state_t;

    state_t                state, state_n;
    logic                  accept;
    logic                  timeout;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         wcnt;
    logic                  d_ale, d_rd, d_wr, d_oe, d_done;

    assign req_ready = (state == IDLE) || (state == T4);
    assign accept    = req && req_ready;

`ifdef BUS_MASTER_WAIT_STATE_EN
    assign timeout = (state == TW) && !READY && (wcnt == CW'(WAIT_LIMIT - 1));
`else
    logic unused_nowait;
    assign timeout       = 1'b0;
    assign unused_nowait = ^{READY, wcnt};
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = T1;
            T1:   state_n = T2;
            T2:   state_n = T3;
`ifdef BUS_MASTER_WAIT_STATE_EN
            T3:   state_n = READY ? T4 : TW;
            TW:   state_n = (READY || timeout) ? T4 : TW;
`else
            T3:   state_n = T4;
            TW:   state_n = IDLE;
`endif
            T4:   state_n = accept ? T1 : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        d_ale  = (state_n == T1);
        d_rd   = 1'b1;
        d_wr   = 1'b1;
        d_oe   = 1'b0;
        d_done = (state_n == T4);
        if (state_n == T2 || state_n == T3 || state_n == TW) begin
            d_rd = wr_q;
            d_wr = !wr_q;
        end
        if (state_n == T2 || state_n == T3 || state_n == TW || state_n == T4)
            d_oe = wr_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ALE      <= 1'b0;
            RD       <= 1'b1;
            WR       <= 1'b1;
            IOM      <= 1'b0;
            Address  <= '0;
            data_out <= '0;
            data_oe  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            wcnt     <= '0;
        end else begin
            ALE     <= d_ale;
            RD      <= d_rd;
            WR      <= d_wr;
            data_oe <= d_oe;
            done    <= d_done;
            err     <= timeout;
            wcnt    <= (state == TW) ? wcnt + 1'b1 : '0;
            if (accept) begin
                Address <= req_addr;
                IOM     <= req_io;
                wr_q    <= req_write;
                wdata_q <= req_wdata;
            end
            if (state_n == T2 && wr_q)
                data_out <= wdata_q;
            if ((state == T3 || state == TW) && state_n == T4 && !wr_q && !timeout)
                rdata <= data_in;
        end
    end

endmodule

// File: tb/tb_bus_master_8088.sv
// Directed bench for bus_master_8088: reads, writes, back-to-back, reset abort.
module tb_bus_master_8088;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        req = 1'b0;
    logic        req_write = 1'b0;
    logic        req_io = 1'b0;
    logic [19:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, done, err, ALE, IOM, RD, WR, data_oe;
    logic [7:0]  rdata, data_out;
    logic [19:0] Address;
    logic [7:0]  data_in = '0;
    logic        READY = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    wire [7:0] ctl = {ALE, IOM, RD, WR, data_oe, done, err, req_ready};

    always #5 CLK = ~CLK;

    bus_master_8088 dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .done(done), .err(err), .rdata(rdata),
        .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .Address(Address),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .READY(READY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 8'b0011_0001) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want %b", ctl, 8'b0011_0001);
        end
        n_cmp++;
        if ({Address, data_out, rdata} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {Address, data_out, rdata});
        end
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_mem_read();
        req = 1'b1; req_write = 1'b0; req_io = 1'b0;
        req_addr = 20'h00010;
        tick();
        req = 1'b0;
        n_cmp++;
        if (ctl !== 8'b1011_0000 || Address !== 20'h00010) begin
            n_bad++;
            $display("FAIL mrd_t1: got %b/%h want 10110000/00010", ctl, Address);
        end
        data_in = 8'hA5;
        tick();
        n_cmp++;
        if (ctl !== 8'b0001_0000) begin
            n_bad++;
            $display("FAIL mrd_t2: got %b want 00010000", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0001_0000) begin
            n_bad++;
            $display("FAIL mrd_t3: got %b want 00010000", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0101 || rdata !== 8'hA5) begin
            n_bad++;
            $display("FAIL mrd_t4: got %b/%h want 00110101/a5", ctl, rdata);
        end
        data_in = 8'h00;
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0001 || rdata !== 8'hA5 || Address !== 20'h00010) begin
            n_bad++;
            $display("FAIL mrd_idle: got %b/%h/%h want 00110001/a5/00010",
                     ctl, rdata, Address);
        end
    endtask

    task automatic test_io_write();
        req = 1'b1; req_write = 1'b1; req_io = 1'b1;
        req_addr = 20'h003F8; req_wdata = 8'h3C;
        tick();
        req = 1'b0;
        n_cmp++;
        if (ctl !== 8'b1111_0000 || Address !== 20'h003F8) begin
            n_bad++;
            $display("FAIL iow_t1: got %b/%h want 11110000/003f8", ctl, Address);
        end
        tick();
        req_wdata = 8'hFF; req_addr = 20'h12345; req_io = 1'b0;
        n_cmp++;
        if (ctl !== 8'b0110_1000 || data_out !== 8'h3C) begin
            n_bad++;
            $display("FAIL iow_t2: got %b/%h want 01101000/3c", ctl, data_out);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0110_1000 || data_out !== 8'h3C || Address !== 20'h003F8) begin
            n_bad++;
            $display("FAIL iow_t3: got %b/%h/%h want 01101000/3c/003f8",
                     ctl, data_out, Address);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0111_1101 || data_out !== 8'h3C) begin
            n_bad++;
            $display("FAIL iow_t4: got %b/%h want 01111101/3c", ctl, data_out);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0111_0001 || Address !== 20'h003F8) begin
            n_bad++;
            $display("FAIL iow_idle: got %b/%h want 01110001/003f8", ctl, Address);
        end
    endtask

    task automatic test_back_to_back();
        req = 1'b1; req_write = 1'b0; req_io = 1'b0;
        req_addr = 20'h00100;
        tick();
        n_cmp++;
        if (ctl !== 8'b1011_0000 || Address !== 20'h00100) begin
            n_bad++;
            $display("FAIL b2b_t1a: got %b/%h want 10110000/00100", ctl, Address);
        end
        req_addr = 20'h00101;
        data_in = 8'h11;
        tick();
        tick();
        n_cmp++;
        if (Address !== 20'h00100) begin
            n_bad++;
            $display("FAIL b2b_hold: got %h want 00100", Address);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0101 || rdata !== 8'h11) begin
            n_bad++;
            $display("FAIL b2b_t4a: got %b/%h want 00110101/11", ctl, rdata);
        end
        tick();
        req = 1'b0;
        data_in = 8'h22;
        n_cmp++;
        if (ctl !== 8'b1011_0000 || Address !== 20'h00101) begin
            n_bad++;
            $display("FAIL b2b_t1b: got %b/%h want 10110000/00101", ctl, Address);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0101 || rdata !== 8'h22) begin
            n_bad++;
            $display("FAIL b2b_t4b: got %b/%h want 00110101/22", ctl, rdata);
        end
        tick();
    endtask

`ifndef BUS_MASTER_WAIT_STATE_EN
    task automatic test_ready_ignored();
        READY = 1'b0;
        req = 1'b1; req_write = 1'b0; req_io = 1'b0;
        req_addr = 20'h00200;
        data_in = 8'h5A;
        tick();
        req = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0101 || rdata !== 8'h5A) begin
            n_bad++;
            $display("FAIL nowait_t4: got %b/%h want 00110101/5a", ctl, rdata);
        end
        READY = 1'b1;
        tick();
    endtask
`else
    task automatic test_wait_states();
        req = 1'b1; req_write = 1'b0; req_io = 1'b0;
        req_addr = 20'h00300;
        data_in = 8'h66;
        tick();
        req = 1'b0;
        tick();
        READY = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (ctl !== 8'b0001_0000) begin
            n_bad++;
            $display("FAIL ws_tw2: got %b want 00010000", ctl);
        end
        tick();
        READY = 1'b1;
        n_cmp++;
        if (ctl !== 8'b0001_0000) begin
            n_bad++;
            $display("FAIL ws_tw3: got %b want 00010000", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0101 || rdata !== 8'h66) begin
            n_bad++;
            $display("FAIL ws_t4: got %b/%h want 00110101/66", ctl, rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        req = 1'b1; req_write = 1'b0; req_io = 1'b0;
        req_addr = 20'h00400;
        data_in = 8'h99;
        tick();
        req = 1'b0;
        tick();
        READY = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (ctl !== 8'b0001_0000) begin
            n_bad++;
            $display("FAIL to_tw15: got %b want 00010000", ctl);
        end
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0111 || rdata !== 8'h66) begin
            n_bad++;
            $display("FAIL to_t4: got %b/%h want 00110111/66", ctl, rdata);
        end
        READY = 1'b1;
        tick();
    endtask
`endif

    task automatic test_reset_abort();
        req = 1'b1; req_write = 1'b1; req_io = 1'b0;
        req_addr = 20'h00500; req_wdata = 8'h81;
        tick();
        req = 1'b0;
        tick();
        n_cmp++;
        if (ctl !== 8'b0010_1000) begin
            n_bad++;
            $display("FAIL rst_pre: got %b want 00101000", ctl);
        end
        #2 RESET = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 8'b0011_0001 || Address !== 20'h0 || data_out !== 8'h0) begin
            n_bad++;
            $display("FAIL rst_async: got %b/%h/%h want 00110001/0/0",
                     ctl, Address, data_out);
        end
        tick();
        RESET = 1'b0;
        n_cmp++;
        if (ctl !== 8'b0011_0001) begin
            n_bad++;
            $display("FAIL rst_nodone: got %b want 00110001", ctl);
        end
        req = 1'b1; req_write = 1'b0;
        req_addr = 20'h00055;
        data_in = 8'h77;
        tick();
        req = 1'b0;
        n_cmp++;
        if (ctl !== 8'b1011_0000 || Address !== 20'h00055) begin
            n_bad++;
            $display("FAIL rst_newt1: got %b/%h want 10110000/00055", ctl, Address);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (ctl !== 8'b0011_0101 || rdata !== 8'h77) begin
            n_bad++;
            $display("FAIL rst_newt4: got %b/%h want 00110101/77", ctl, rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_mem_read();
        test_io_write();
        test_back_to_back();
`ifndef BUS_MASTER_WAIT_STATE_EN
        test_ready_ignored();
`else
        test_wait_states();
        test_timeout();
`endif
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
